// File: rtl/laser_multi_pkg.sv
// Shared state encoding and sizing helpers for the multi-circle laser placement engine.
package laser_multi_pkg;
  typedef enum logic [1:0] {LOAD, SCAN, UNION, DONE_ST} state_t;

  function automatic int f_beats(input int n_points, input int lanes);
    return n_points / lanes;
  endfunction

  function automatic int f_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int f_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Derived constants at the default configuration (40 points, 20 lanes).
  localparam int BEATS = f_beats(40, 20);
  localparam int CNT_W = f_cnt_w(40);
  localparam int IDX_W = f_idx_w(40);
endpackage

// File: rtl/laser_cover_check.sv
// Combinational test: is point (px,py) within squared radius R2 of candidate (cx,cy)?
module laser_cover_check #(
  parameter int COORD_W = 4,
  parameter int R2      = 16
) (
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  output logic               o_cover
);
  localparam logic [31:0] R2_U = R2;

  logic [COORD_W-1:0]   w_dx, w_dy;
  logic [2*COORD_W-1:0] w_dx2, w_dy2;
  logic [2*COORD_W:0]   w_sum;

  assign w_dx    = (i_px >= i_cx) ? i_px - i_cx : i_cx - i_px;
  assign w_dy    = (i_py >= i_cy) ? i_py - i_cy : i_cy - i_py;
  assign w_dx2   = (2*COORD_W)'(w_dx) * (2*COORD_W)'(w_dx);
  assign w_dy2   = (2*COORD_W)'(w_dy) * (2*COORD_W)'(w_dy);
  assign w_sum   = {1'b0, w_dx2} + {1'b0, w_dy2};
  assign o_cover = 32'(w_sum) <= R2_U;
endmodule

// File: rtl/laser_multi_cover.sv
// Places N_CIRCLES fixed-radius circles over loaded points by round-robin coordinate
// descent: each full-grid scan re-optimises one circle against the others' frozen masks.
module laser_multi_cover
  import laser_multi_pkg::*;
#(
  parameter int COORD_W    = 4,
  parameter int N_POINTS   = 40,
  parameter int N_CIRCLES  = 2,
  parameter int R2         = 16,
  parameter int LANES      = 20,
  parameter int MAX_ROUNDS = 8
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [COORD_W-1:0]             X,
  input  logic [COORD_W-1:0]             Y,
  output logic [N_CIRCLES*COORD_W-1:0]   C_X,
  output logic [N_CIRCLES*COORD_W-1:0]   C_Y,
  output logic [$clog2(N_POINTS+1)-1:0]  COUNT,
  output logic                           DONE
);
  localparam int BEAT_N  = f_beats(N_POINTS, LANES);
  localparam int CNT_WD  = f_cnt_w(N_POINTS);
  localparam int IDX_WD  = f_idx_w(N_POINTS);
  localparam int BEAT_WD = f_idx_w(BEAT_N);
  localparam int K_WD    = f_idx_w(N_CIRCLES);
  localparam int RND_WD  = f_cnt_w(MAX_ROUNDS);
  localparam logic [COORD_W-1:0] CMAX = '1;

  state_t r_state, w_nxt;

  logic [N_POINTS-1:0][COORD_W-1:0]  r_px, r_py;
  logic [IDX_WD-1:0]                 r_idx;
  logic [N_CIRCLES-1:0][COORD_W-1:0] r_cx, r_cy;
  logic [N_CIRCLES-1:0][N_POINTS-1:0] r_mask;
  logic [K_WD-1:0]                   r_k;
  logic [RND_WD-1:0]                 r_round;
  logic                              r_changed;
  logic [COORD_W-1:0]                r_cand_x, r_cand_y, r_best_x, r_best_y;
  logic [BEAT_WD-1:0]                r_beat;
  logic [CNT_WD-1:0]                 r_acc, r_best_cnt, r_count;
  logic [N_POINTS-1:0]               r_cur_mask, r_best_mask;

  logic                w_accept, w_last_pt, w_last_beat, w_last_cand, w_last_k;
  logic                w_take, w_chg, w_term, w_scan_end;
  logic [IDX_WD-1:0]   w_base;
  logic [N_POINTS-1:0] w_other, w_allor, w_full, w_fin_mask;
  logic [LANES-1:0]    w_cov, w_exc, w_uni, w_pc_in;
  logic [CNT_WD-1:0]   w_pc, w_tot;
  logic [COORD_W-1:0]  w_fin_x, w_fin_y;

  assign w_accept    = IN_VALID && (r_state == LOAD);
  assign w_last_pt   = r_idx == IDX_WD'(N_POINTS - 1);
  assign w_last_beat = r_beat == BEAT_WD'(BEAT_N - 1);
  assign w_last_cand = (r_cand_x == CMAX) && (r_cand_y == CMAX);
  assign w_last_k    = r_k == K_WD'(N_CIRCLES - 1);
  assign w_scan_end  = (r_state == SCAN) && w_last_beat && w_last_cand;
  assign w_base      = IDX_WD'(32'(r_beat) * LANES);

  // Masks of every circle, and of every circle except the one being re-optimised.
  always_comb begin
    w_other = '0;
    w_allor = '0;
    for (int j = 0; j < N_CIRCLES; j++) begin
      w_allor = w_allor | r_mask[j];
      if (K_WD'(j) != r_k) w_other = w_other | r_mask[j];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_WD-1:0] w_pi;
    assign w_pi = w_base + IDX_WD'(l);
    laser_cover_check #(.COORD_W(COORD_W), .R2(R2)) u_chk (
      .i_px(r_px[w_pi]), .i_py(r_py[w_pi]),
      .i_cx(r_cand_x),   .i_cy(r_cand_y),
      .o_cover(w_cov[l])
    );
    assign w_exc[l] = w_cov[l] & ~w_other[w_pi];
    assign w_uni[l] = w_allor[w_pi];
  end

  // One popcount serves both the scan (exclusive cover) and the final union.
  assign w_pc_in = (r_state == UNION) ? w_uni : w_exc;
  always_comb begin
    w_pc = '0;
    for (int l = 0; l < LANES; l++) w_pc = w_pc + CNT_WD'(w_pc_in[l]);
  end
  assign w_tot = r_acc + w_pc;

  always_comb begin
    w_full = r_cur_mask;
    for (int l = 0; l < LANES; l++) w_full[w_base + IDX_WD'(l)] = w_cov[l];
  end

  // Best-so-far including the candidate finishing this cycle; ties favour the later one.
  assign w_take     = w_tot >= r_best_cnt;
  assign w_fin_x    = w_take ? r_cand_x : r_best_x;
  assign w_fin_y    = w_take ? r_cand_y : r_best_y;
  assign w_fin_mask = w_take ? w_full : r_best_mask;
  assign w_chg      = r_changed || (r_round == '0) ||
                      (w_fin_x != r_cx[r_k]) || (w_fin_y != r_cy[r_k]);
  assign w_term     = !w_chg || (32'(r_round) + 32'd1 == 32'(MAX_ROUNDS));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      LOAD:    if (w_accept && w_last_pt) w_nxt = SCAN;
      SCAN:    if (w_scan_end && w_last_k && w_term) w_nxt = UNION;
      UNION:   if (w_last_beat) w_nxt = DONE_ST;
      DONE_ST: w_nxt = LOAD;
      default: w_nxt = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= LOAD;
    else     r_state <= w_nxt;
  end

  // Leaving DONE_ST is the LOAD entry that clears the previous job's result.
  always_ff @(posedge CLK) begin
    if (RST || (r_state == DONE_ST)) begin
      r_idx       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_mask      <= '0;
      r_k         <= '0;
      r_round     <= '0;
      r_changed   <= 1'b0;
      r_cand_x    <= '0;
      r_cand_y    <= '0;
      r_best_x    <= '0;
      r_best_y    <= '0;
      r_beat      <= '0;
      r_acc       <= '0;
      r_best_cnt  <= '0;
      r_count     <= '0;
      r_cur_mask  <= '0;
      r_best_mask <= '0;
    end else begin
      case (r_state)
        LOAD: if (w_accept) begin
          r_px[r_idx] <= X;
          r_py[r_idx] <= Y;
          r_idx       <= w_last_pt ? '0 : r_idx + 1'b1;
        end
        SCAN: begin
          r_cur_mask <= w_full;
          if (!w_last_beat) begin
            r_beat <= r_beat + 1'b1;
            r_acc  <= w_tot;
          end else begin
            r_beat   <= '0;
            r_acc    <= '0;
            r_cand_x <= r_cand_x + 1'b1;
            if (r_cand_x == CMAX) r_cand_y <= r_cand_y + 1'b1;
            if (w_last_cand) begin
              r_cx[r_k]   <= w_fin_x;
              r_cy[r_k]   <= w_fin_y;
              r_mask[r_k] <= w_fin_mask;
              r_best_cnt  <= '0;
              if (w_last_k) begin
                r_k       <= '0;
                r_round   <= r_round + 1'b1;
                r_changed <= 1'b0;
              end else begin
                r_k       <= r_k + 1'b1;
                r_changed <= w_chg;
              end
            end else if (w_take) begin
              r_best_x    <= r_cand_x;
              r_best_y    <= r_cand_y;
              r_best_cnt  <= w_tot;
              r_best_mask <= w_full;
            end
          end
        end
        UNION: begin
          if (!w_last_beat) begin
            r_beat <= r_beat + 1'b1;
            r_acc  <= w_tot;
          end else begin
            r_beat  <= '0;
            r_acc   <= '0;
            r_count <= w_tot;
          end
        end
        default: ;
      endcase
    end
  end

  assign IN_READY = (r_state == LOAD);
  assign DONE     = (r_state == DONE_ST);
  assign C_X      = r_cx;
  assign C_Y      = r_cy;
  assign COUNT    = r_count;
endmodule
